// File: rtl/picorv32_mem_arbiter.sv
// Round-robin arbiter sharing one picorv32 native memory port between two masters.
// Grant is registered; a watchdog optionally aborts transfers the slave never readies.
module picorv32_mem_arbiter #(
    parameter int unsigned TIMEOUT   = 1024,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_mem_valid,
    input  logic        m0_mem_instr,
    input  logic [31:0] m0_mem_addr,
    input  logic [31:0] m0_mem_wdata,
    input  logic [3:0]  m0_mem_wstrb,
    output logic        m0_mem_ready,
    output logic [31:0] m0_mem_rdata,
    input  logic        m1_mem_valid,
    input  logic        m1_mem_instr,
    input  logic [31:0] m1_mem_addr,
    input  logic [31:0] m1_mem_wdata,
    input  logic [3:0]  m1_mem_wstrb,
    output logic        m1_mem_ready,
    output logic [31:0] m1_mem_rdata,
    output logic        s_mem_valid,
    output logic        s_mem_instr,
    output logic [31:0] s_mem_addr,
    output logic [31:0] s_mem_wdata,
    output logic [3:0]  s_mem_wstrb,
    input  logic        s_mem_ready,
    input  logic [31:0] s_mem_rdata,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    localparam bit              WDOG_EN   = (TIMEOUT != 0);
    localparam int              CW        = WDOG_EN ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]   CNT_LIMIT = WDOG_EN ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0]   CNT_MAX   = '1;

    logic          state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          last_m1_q, last_m1_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;

    logic busy, g0, g1, expire, done;

    assign busy   = (state_q == ST_BUSY);
    assign g0     = busy & grant_q[0];
    assign g1     = busy & grant_q[1];
    // A slave ready in the limit cycle takes priority over the abort.
    assign expire = busy && WDOG_EN && (wait_cnt_q == CNT_LIMIT) && !s_mem_ready;
    assign done   = busy && (s_mem_ready || expire);

    assign grant       = grant_q;
    assign timeout_err = expire;

    always_comb begin
        s_mem_valid  = 1'b0;
        s_mem_instr  = 1'b0;
        s_mem_addr   = '0;
        s_mem_wdata  = '0;
        s_mem_wstrb  = '0;
        m0_mem_ready = 1'b0;
        m0_mem_rdata = '0;
        m1_mem_ready = 1'b0;
        m1_mem_rdata = '0;
        if (g0) begin
            s_mem_valid  = m0_mem_valid;
            s_mem_instr  = m0_mem_instr;
            s_mem_addr   = m0_mem_addr;
            s_mem_wdata  = m0_mem_wdata;
            s_mem_wstrb  = m0_mem_wstrb;
            m0_mem_ready = done;
            if (done) begin
                m0_mem_rdata = expire ? ERR_RDATA : s_mem_rdata;
            end
        end else if (g1) begin
            s_mem_valid  = m1_mem_valid;
            s_mem_instr  = m1_mem_instr;
            s_mem_addr   = m1_mem_addr;
            s_mem_wdata  = m1_mem_wdata;
            s_mem_wstrb  = m1_mem_wstrb;
            m1_mem_ready = done;
            if (done) begin
                m1_mem_rdata = expire ? ERR_RDATA : s_mem_rdata;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_m1_d  = last_m1_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_mem_valid || m1_mem_valid) begin
                    state_d    = ST_BUSY;
                    wait_cnt_d = '0;
                    if (m0_mem_valid && (!m1_mem_valid || last_m1_q)) begin
                        grant_d   = 2'b01;
                        last_m1_d = 1'b0;
                    end else begin
                        grant_d   = 2'b10;
                        last_m1_d = 1'b1;
                    end
                end
            end
            default: begin
                if (done) begin
                    state_d = ST_IDLE;
                    grant_d = 2'b00;
                end else if (wait_cnt_q != CNT_MAX) begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= 2'b00;
            last_m1_q  <= 1'b1;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_m1_q  <= last_m1_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Bench for picorv32_mem_arbiter: scripted masters, a latency-programmable slave
// and per-master queues of expected completions.
module tb_picorv32_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_mem_valid = 1'b0, m0_mem_instr = 1'b0;
    logic [31:0] m0_mem_addr = '0, m0_mem_wdata = '0;
    logic [3:0]  m0_mem_wstrb = '0;
    logic        m0_mem_ready;
    logic [31:0] m0_mem_rdata;
    logic        m1_mem_valid = 1'b0, m1_mem_instr = 1'b0;
    logic [31:0] m1_mem_addr = '0, m1_mem_wdata = '0;
    logic [3:0]  m1_mem_wstrb = '0;
    logic        m1_mem_ready;
    logic [31:0] m1_mem_rdata;
    logic        s_mem_valid, s_mem_instr;
    logic [31:0] s_mem_addr, s_mem_wdata;
    logic [3:0]  s_mem_wstrb;
    logic        s_mem_ready;
    logic [31:0] s_mem_rdata;
    logic [1:0]  grant;
    logic        timeout_err;

    always #5 clk = ~clk;

    picorv32_mem_arbiter #(.TIMEOUT(16), .ERR_RDATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .reset(reset),
        .m0_mem_valid(m0_mem_valid), .m0_mem_instr(m0_mem_instr), .m0_mem_addr(m0_mem_addr),
        .m0_mem_wdata(m0_mem_wdata), .m0_mem_wstrb(m0_mem_wstrb),
        .m0_mem_ready(m0_mem_ready), .m0_mem_rdata(m0_mem_rdata),
        .m1_mem_valid(m1_mem_valid), .m1_mem_instr(m1_mem_instr), .m1_mem_addr(m1_mem_addr),
        .m1_mem_wdata(m1_mem_wdata), .m1_mem_wstrb(m1_mem_wstrb),
        .m1_mem_ready(m1_mem_ready), .m1_mem_rdata(m1_mem_rdata),
        .s_mem_valid(s_mem_valid), .s_mem_instr(s_mem_instr), .s_mem_addr(s_mem_addr),
        .s_mem_wdata(s_mem_wdata), .s_mem_wstrb(s_mem_wstrb),
        .s_mem_ready(s_mem_ready), .s_mem_rdata(s_mem_rdata),
        .grant(grant), .timeout_err(timeout_err)
    );

    typedef struct packed { logic [31:0] rd; logic to; } exp_t;
    typedef struct packed { logic [1:0] g; logic [31:0] a; logic [3:0] s; } slv_t;

    int total = 0, bad = 0, cyc = 0;
    int c0 = 0, c1 = 0, tcnt = 0, rcyc0 = 0, rcyc1 = 0;
    exp_t q0[$], q1[$];
    logic [1:0] glog[$];
    int gcyc[$];
    slv_t slog[$];
    logic [1:0] grant_prev = 2'b00;

    bit slv_en = 1'b0;
    int slv_lat = 0, slv_cnt = 0;

    logic [138:0] outs_w;
    assign outs_w = {s_mem_valid, s_mem_instr, s_mem_addr, s_mem_wdata, s_mem_wstrb,
                     m0_mem_ready, m1_mem_ready, m0_mem_rdata, m1_mem_rdata, grant, timeout_err};

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return (a == 32'h100) ? 32'h1234_5678 : (a ^ 32'hCAFE_0000);
    endfunction

    // Slave: ready after slv_lat cycles of continuous valid, one-cycle pulse.
    initial begin
        s_mem_ready = 1'b0;
        s_mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            s_mem_ready = 1'b0;
            if (slv_en && s_mem_valid) begin
                if (slv_cnt == slv_lat) begin
                    s_mem_ready = 1'b1;
                    s_mem_rdata = rd_model(s_mem_addr);
                    slv_cnt = 0;
                end else begin
                    slv_cnt++;
                end
            end else begin
                slv_cnt = 0;
            end
        end
    end

    // Scoreboard: pops per-master expectations on each master ready.
    initial forever begin
        exp_t e;
        @(negedge clk);
        cyc++;
        if (grant != 2'b00 && grant_prev == 2'b00) begin
            glog.push_back(grant);
            gcyc.push_back(cyc);
        end
        grant_prev = grant;
        if (s_mem_valid && s_mem_ready) slog.push_back({grant, s_mem_addr, s_mem_wstrb});
        if (timeout_err) tcnt++;
        if (m0_mem_ready) begin
            c0++; rcyc0 = cyc; total++;
            if (q0.size() == 0) begin
                bad++; $display("FAIL m0_unexpected_ready got=1 exp=0 rdata=%h", m0_mem_rdata);
            end else begin
                e = q0.pop_front();
                if (m0_mem_rdata !== e.rd || timeout_err !== e.to) begin
                    bad++;
                    $display("FAIL m0_completion got rdata=%h terr=%b exp rdata=%h terr=%b",
                             m0_mem_rdata, timeout_err, e.rd, e.to);
                end
            end
        end
        if (m1_mem_ready) begin
            c1++; rcyc1 = cyc; total++;
            if (q1.size() == 0) begin
                bad++; $display("FAIL m1_unexpected_ready got=1 exp=0 rdata=%h", m1_mem_rdata);
            end else begin
                e = q1.pop_front();
                if (m1_mem_rdata !== e.rd || timeout_err !== e.to) begin
                    bad++;
                    $display("FAIL m1_completion got rdata=%h terr=%b exp rdata=%h terr=%b",
                             m1_mem_rdata, timeout_err, e.rd, e.to);
                end
            end
        end
        if (grant == 2'b10) begin
            total++;
            if (m0_mem_ready !== 1'b0 || m0_mem_rdata !== 32'h0) begin
                bad++; $display("FAIL m0_nongranted got ready=%b rdata=%h exp 0", m0_mem_ready, m0_mem_rdata);
            end
        end
        if (grant == 2'b01) begin
            total++;
            if (m1_mem_ready !== 1'b0 || m1_mem_rdata !== 32'h0) begin
                bad++; $display("FAIL m1_nongranted got ready=%b rdata=%h exp 0", m1_mem_ready, m1_mem_rdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=hang exp=finish");
        $fatal(1);
    end

    task automatic clear_logs();
        glog.delete(); gcyc.delete(); slog.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; m0_mem_valid = 1'b0; m1_mem_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // One master transfer; caller must be away from the rising edge.
    task automatic m_xfer(input int m, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input logic ins, input logic [31:0] erd,
                          input bit eto, input bit hold);
        exp_t e;
        bit got;
        e.rd = erd; e.to = eto;
        got = 1'b0;
        if (m == 0) begin
            q0.push_back(e);
            m0_mem_addr = a; m0_mem_wdata = wd; m0_mem_wstrb = ws; m0_mem_instr = ins; m0_mem_valid = 1'b1;
        end else begin
            q1.push_back(e);
            m1_mem_addr = a; m1_mem_wdata = wd; m1_mem_wstrb = ws; m1_mem_instr = ins; m1_mem_valid = 1'b1;
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((m == 0 && m0_mem_ready) || (m == 1 && m1_mem_ready)) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL xfer_wait m%0d addr=%h got=no_ready exp=ready", m, a);
        end
        @(posedge clk); #1;
        if (!hold) begin
            if (m == 0) m0_mem_valid = 1'b0;
            else        m1_mem_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        m0_mem_valid = 1'b1; m1_mem_valid = 1'b1; m0_mem_addr = 32'h44; m1_mem_wstrb = 4'hF;
        @(negedge clk);
        total++;
        if (outs_w !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", outs_w); end
        @(posedge clk); #1;
        m0_mem_valid = 1'b0; m1_mem_valid = 1'b0; m1_mem_wstrb = 4'h0;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (outs_w !== '0) begin bad++; $display("FAIL idle_outputs got=%h exp=0", outs_w); end
    endtask

    task automatic test_single();
        exp_t e;
        int c0s, wait_i;
        clear_logs();
        c0s = c0; wait_i = -1;
        slv_en = 1'b1; slv_lat = 2;
        @(posedge clk); #1;
        e.rd = 32'h1234_5678; e.to = 1'b0;
        q0.push_back(e);
        m0_mem_addr = 32'h100; m0_mem_wdata = 32'h0; m0_mem_wstrb = 4'h0; m0_mem_instr = 1'b1; m0_mem_valid = 1'b1;
        @(negedge clk);
        total++;
        if (s_mem_valid !== 1'b0 || grant !== 2'b00) begin
            bad++; $display("FAIL single_req_cycle got valid=%b grant=%b exp 0 00", s_mem_valid, grant);
        end
        @(negedge clk);
        total++;
        if (s_mem_valid !== 1'b1 || grant !== 2'b01 || s_mem_addr !== 32'h100 || s_mem_instr !== 1'b1) begin
            bad++; $display("FAIL single_grant got valid=%b grant=%b addr=%h instr=%b exp 1 01 100 1",
                            s_mem_valid, grant, s_mem_addr, s_mem_instr);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m0_mem_ready) begin wait_i = i; break; end
        end
        total++;
        if (wait_i != 1 || grant !== 2'b01) begin
            bad++; $display("FAIL single_latency got i=%0d grant=%b exp i=1 grant=01", wait_i, grant);
        end
        @(posedge clk); #1;
        m0_mem_valid = 1'b0; m0_mem_instr = 1'b0;
        @(negedge clk);
        total++;
        if (grant !== 2'b00 || m0_mem_ready !== 1'b0) begin
            bad++; $display("FAIL single_release got grant=%b ready=%b exp 00 0", grant, m0_mem_ready);
        end
        repeat (3) @(negedge clk);
        total++;
        if (c0 - c0s != 1) begin bad++; $display("FAIL single_pulses got=%0d exp=1", c0 - c0s); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        clear_logs();
        slv_en = 1'b1; slv_lat = 1;
        fork
            m_xfer(0, 32'h400, 32'h11, 4'hF, 1'b0, rd_model(32'h400), 1'b0, 1'b0);
            m_xfer(1, 32'h800, 32'h22, 4'h0, 1'b0, rd_model(32'h800), 1'b0, 1'b0);
        join
        repeat (2) @(negedge clk);
        total++;
        if (glog.size() != 2) begin
            bad++; $display("FAIL sim_grants got count=%0d exp=2", glog.size());
        end else if (glog[0] !== 2'b01 || glog[1] !== 2'b10 || gcyc[1] != rcyc0 + 2) begin
            bad++; $display("FAIL sim_order got %b,%b gap=%0d exp 01,10 gap=2", glog[0], glog[1], gcyc[1] - rcyc0);
        end
        total++;
        if (slog.size() != 2) begin
            bad++; $display("FAIL sim_slave got count=%0d exp=2", slog.size());
        end else if (slog[0].a !== 32'h400 || slog[1].a !== 32'h800) begin
            bad++; $display("FAIL sim_addr got %h,%h exp 400,800", slog[0].a, slog[1].a);
        end
    endtask

    task automatic test_contention();
        int c0s, c1s, errs;
        clear_logs();
        c0s = c0; c1s = c1;
        slv_en = 1'b1; slv_lat = 0;
        @(posedge clk); #1;
        fork
            begin
                for (int k = 0; k < 4; k++)
                    m_xfer(0, 32'h2000 + 32'(k * 4), 32'(k), 4'b1111, 1'b0,
                           rd_model(32'h2000 + 32'(k * 4)), 1'b0, k < 3);
            end
            begin
                for (int j = 0; j < 4; j++)
                    m_xfer(1, 32'h3000 + 32'(j * 4), 32'(j + 8), 4'b0011, 1'b0,
                           rd_model(32'h3000 + 32'(j * 4)), 1'b0, j < 3);
            end
        join
        repeat (2) @(negedge clk);
        errs = 0;
        for (int i = 0; i < glog.size(); i++)
            if (glog[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) errs++;
        total++;
        if (glog.size() != 8 || errs != 0) begin
            bad++; $display("FAIL rr_order got count=%0d wrong=%0d exp count=8 wrong=0", glog.size(), errs);
        end
        total++;
        if (c0 - c0s != 4 || c1 - c1s != 4) begin
            bad++; $display("FAIL rr_completions got m0=%0d m1=%0d exp 4 4", c0 - c0s, c1 - c1s);
        end
        errs = 0;
        for (int i = 0; i < slog.size(); i++)
            if (slog[i].s !== ((slog[i].g == 2'b10) ? 4'b0011 : 4'b1111)) errs++;
        total++;
        if (slog.size() != 8 || errs != 0) begin
            bad++; $display("FAIL rr_wstrb got count=%0d wrong=%0d exp count=8 wrong=0", slog.size(), errs);
        end
    endtask

    task automatic test_watchdog();
        int t0;
        clear_logs();
        t0 = tcnt;
        slv_en = 1'b0;
        m_xfer(1, 32'hC00, 32'h55, 4'hF, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);
        @(negedge clk);
        total++;
        if (glog.size() != 1 || rcyc1 - gcyc[0] != 15) begin
            bad++; $display("FAIL wd_cycle got grants=%0d offset=%0d exp 1 15", glog.size(), rcyc1 - gcyc[0]);
        end
        total++;
        if (tcnt - t0 != 1) begin bad++; $display("FAIL wd_err_pulses got=%0d exp=1", tcnt - t0); end
        @(posedge clk); #2;
        s_mem_ready = 1'b1; s_mem_rdata = 32'h7777_7777;
        @(negedge clk);
        total++;
        if (m0_mem_ready !== 1'b0 || m1_mem_ready !== 1'b0 || timeout_err !== 1'b0) begin
            bad++; $display("FAIL wd_stray got m0=%b m1=%b terr=%b exp 0 0 0", m0_mem_ready, m1_mem_ready, timeout_err);
        end
    endtask

    task automatic test_wd_boundary();
        int t0;
        clear_logs();
        t0 = tcnt;
        slv_en = 1'b1; slv_lat = 15;
        @(posedge clk); #1;
        m_xfer(0, 32'hD00, 32'h0, 4'h0, 1'b0, rd_model(32'hD00), 1'b0, 1'b0);
        @(negedge clk);
        total++;
        if (glog.size() != 1 || rcyc0 - gcyc[0] != 15 || tcnt != t0) begin
            bad++; $display("FAIL wd_boundary got offset=%0d errs=%0d exp 15 0", rcyc0 - gcyc[0], tcnt - t0);
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        slv_en = 1'b0;
        @(posedge clk); #1;
        m0_mem_addr = 32'hE00; m0_mem_wstrb = 4'h0; m0_mem_valid = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (grant !== 2'b01 || s_mem_valid !== 1'b1) begin
            bad++; $display("FAIL mid_busy got grant=%b valid=%b exp 01 1", grant, s_mem_valid);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        m1_mem_addr = 32'hF00; m1_mem_wstrb = 4'h0; m1_mem_valid = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (outs_w !== '0) begin bad++; $display("FAIL mid_reset_outputs got=%h exp=0", outs_w); end
        clear_logs();
        slv_en = 1'b1; slv_lat = 1;
        fork
            m_xfer(0, 32'hE00, 32'h0, 4'h0, 1'b0, rd_model(32'hE00), 1'b0, 1'b0);
            m_xfer(1, 32'hF00, 32'h0, 4'h0, 1'b0, rd_model(32'hF00), 1'b0, 1'b0);
        join
        @(negedge clk);
        total++;
        if (glog.size() != 2) begin
            bad++; $display("FAIL mid_regrant got count=%0d exp=2", glog.size());
        end else if (glog[0] !== 2'b01 || glog[1] !== 2'b10) begin
            bad++; $display("FAIL mid_tie got %b,%b exp 01,10", glog[0], glog[1]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_contention();
        test_watchdog();
        test_wd_boundary();
        test_reset_mid();
        repeat (2) @(negedge clk);
        total++;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++; $display("FAIL leftover_expect got m0=%0d m1=%0d exp 0 0", q0.size(), q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
